// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-7-segment decode helper for the scan driver.
// Segment bits are active-low with [6:0] = g..a.
package seven_seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [6:0] DECODE_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] decode(input logic [3:0] nibble);
        return DECODE_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern (a..g on bits 0..6).
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg7
);

    // Table lookup of the current digit value
    always_comb begin
        seg7 = decode(nibble);
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: PWM brightness, guard tick,
// per-digit enable/blink, and frame-synchronous capture of the display inputs.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   decimal_points,
    input  logic [NUM_DIGITS-1:0]   digit_enable,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_start
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(BLINK_FRAMES - 1);

    logic [PS_W-1:0]         prescale_r;
    logic [BRIGHT_W-1:0]     phase_r;
    logic [IDX_W-1:0]        index_r;
    logic [FC_W-1:0]         frame_cnt_r;
    logic                    blink_phase_r;
    logic [4*NUM_DIGITS-1:0] shadow_digits_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [NUM_DIGITS-1:0]   shadow_en_r;
    logic [NUM_DIGITS-1:0]   shadow_blink_r;

    logic       tick_s;
    logic       phase_wrap_s;
    logic       frame_edge_s;
    logic [3:0] nibble_s;
    logic       dp_s;
    logic       lit_s;
    logic [6:0] seg7_s;

    assign tick_s       = (prescale_r == PS_MAX);
    assign phase_wrap_s = tick_s && (phase_r == {BRIGHT_W{1'b1}});
    assign frame_edge_s = phase_wrap_s && (index_r == IDX_MAX);

    // Prescaler, PWM phase, digit index and blink timing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescale_r    <= '0;
            phase_r       <= '0;
            index_r       <= '0;
            frame_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else begin
            prescale_r <= tick_s ? PS_W'(0) : prescale_r + PS_W'(1);
            if (tick_s) begin
                phase_r <= phase_r + BRIGHT_W'(1);
            end
            if (phase_wrap_s) begin
                index_r <= frame_edge_s ? IDX_W'(0) : index_r + IDX_W'(1);
            end
            if (frame_edge_s) begin
                if (frame_cnt_r == FC_MAX) begin
                    frame_cnt_r   <= '0;
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    frame_cnt_r <= frame_cnt_r + FC_W'(1);
                end
            end
        end
    end

    // Shadow copy of the display inputs, refreshed only at frame boundaries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_digits_r <= '0;
            shadow_dp_r     <= '0;
            shadow_en_r     <= '0;
            shadow_blink_r  <= '0;
        end else if (frame_edge_s) begin
            shadow_digits_r <= digits;
            shadow_dp_r     <= decimal_points;
            shadow_en_r     <= digit_enable;
            shadow_blink_r  <= blink_mask;
        end
    end

    // Phase 0 of each slot stays dark so the previous digit cannot ghost
    always_comb begin
        nibble_s = shadow_digits_r[int'(index_r)*4 +: 4];
        dp_s     = shadow_dp_r[index_r];
        lit_s    = (phase_r != '0) && (phase_r <= brightness)
                   && shadow_en_r[index_r]
                   && !(shadow_blink_r[index_r] && blink_phase_r);
    end

    seven_seg_decoder u_decoder (
        .nibble (nibble_s),
        .seg7   (seg7_s)
    );

    // Registered pin drivers and frame marker
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            segments    <= SEG_OFF;
            anodes      <= '1;
            frame_start <= 1'b0;
        end else begin
            segments    <= lit_s ? {~dp_s, seg7_s} : SEG_OFF;
            anodes      <= lit_s ? ~(NUM_DIGITS'(1) << index_r) : {NUM_DIGITS{1'b1}};
            frame_start <= frame_edge_s;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: an arithmetic model derived from the
// cycle count since reset predicts every output cycle, plus per-frame duty checks.
module tb_seven_seg_scan_driver;

    localparam int N    = 4;
    localparam int P    = 2;
    localparam int BW   = 2;
    localparam int BF   = 2;
    localparam int SLOT = 4;
    localparam int FRAME = P * SLOT * N;

    localparam logic [6:0] EXP_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] an;
        logic       fs;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   digits = '0;
    logic [3:0]    decimal_points = '0;
    logic [3:0]    digit_enable = '0;
    logic [3:0]    blink_mask = '0;
    logic [BW-1:0] brightness = '0;
    logic [7:0]    segments;
    logic [3:0]    anodes;
    logic          frame_start;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int          n = 0;
    logic [15:0] sh_dig = '0;
    logic [3:0]  sh_dp = '0;
    logic [3:0]  sh_en = '0;
    logic [3:0]  sh_bl = '0;

    logic [7:0] obs_seg;
    logic [3:0] obs_an;
    logic       obs_fs;

    seven_seg_scan_driver #(
        .NUM_DIGITS   (N),
        .PRESCALE     (P),
        .BRIGHT_W     (BW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .digits         (digits),
        .decimal_points (decimal_points),
        .digit_enable   (digit_enable),
        .blink_mask     (blink_mask),
        .brightness     (brightness),
        .segments       (segments),
        .anodes         (anodes),
        .frame_start    (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Predict the next registered output from the model, clock once, compare
    task automatic step();
        exp_t e;
        int   ticks, ph, idx, frame;
        logic bph, lit, bnd;
        if (!rst_n) begin
            e      = '{seg: 8'hFF, an: 4'hF, fs: 1'b0};
            n      = 0;
            sh_dig = '0;
            sh_dp  = '0;
            sh_en  = '0;
            sh_bl  = '0;
        end else begin
            ticks = n / P;
            ph    = ticks % SLOT;
            idx   = (ticks / SLOT) % N;
            frame = ticks / (SLOT * N);
            bph   = ((frame / BF) % 2) == 1;
            lit   = (ph >= 1) && (ph <= int'(brightness)) && sh_en[idx]
                    && !(sh_bl[idx] && bph);
            bnd   = ((n % P) == P - 1) && (ph == SLOT - 1) && (idx == N - 1);
            e.seg = lit ? {~sh_dp[idx], EXP_SEG[sh_dig[idx*4 +: 4]]} : 8'hFF;
            e.an  = lit ? ~(4'b0001 << idx) : 4'hF;
            e.fs  = bnd;
            if (bnd) begin
                sh_dig = digits;
                sh_dp  = decimal_points;
                sh_en  = digit_enable;
                sh_bl  = blink_mask;
            end
            n++;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        obs_seg = segments;
        obs_an  = anodes;
        obs_fs  = frame_start;
        e = sb_q.pop_front();
        chk("segments", {8'h00, obs_seg}, {8'h00, e.seg});
        chk("anodes", {12'h000, obs_an}, {12'h000, e.an});
        chk("frame_start", {15'h0000, obs_fs}, {15'h0000, e.fs});
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic sync_frame();
        int k = 0;
        do begin
            step();
            k++;
        end while (!obs_fs && k < 2 * FRAME + 8);
        chk("sync_frame_start", {15'h0000, obs_fs}, 16'h0001);
    endtask

    // One full frame after a frame_start: count lit cycles, F glyphs and frame markers
    task automatic measure_frame(output int lows, output int fss, output int fglyph);
        lows = 0;
        fss = 0;
        fglyph = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (obs_an != 4'hF) lows++;
            if (obs_fs) fss++;
            if (obs_seg[6:0] == 7'h0E) fglyph++;
        end
    endtask

    initial begin
        int lows, fss, fgl, k;

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            digits         = 16'($urandom);
            decimal_points = 4'($urandom);
            digit_enable   = 4'($urandom);
            blink_mask     = 4'($urandom);
            brightness     = BW'($urandom);
            step();
        end
        chk("reset_seg", {8'h00, segments}, 16'h00FF);
        chk("reset_an", {12'h000, anodes}, 16'h000F);

        // Scan order at full brightness
        rst_n          = 1'b1;
        digits         = 16'h4321;
        decimal_points = 4'h0;
        digit_enable   = 4'hF;
        blink_mask     = 4'h0;
        brightness     = 2'd3;
        sync_frame();
        measure_frame(lows, fss, fgl);
        chk("b3_lit_cycles", 16'(lows), 16'd24);
        chk("b3_frame_starts", 16'(fss), 16'd1);

        // Brightness 1, then 0
        brightness = 2'd1;
        measure_frame(lows, fss, fgl);
        chk("b1_lit_cycles", 16'(lows), 16'd8);
        brightness = 2'd0;
        measure_frame(lows, fss, fgl);
        chk("b0_lit_cycles", 16'(lows), 16'd0);
        chk("b0_frame_starts", 16'(fss), 16'd1);

        // Tear-free capture: change digits inside digit 1's slot
        brightness = 2'd3;
        run(12);
        digits = 16'hFFFF;
        lows = 0;
        fgl = 0;
        for (int i = 12; i < FRAME; i++) begin
            step();
            if (obs_seg[6:0] == 7'h0E) fgl++;
        end
        chk("tear_no_early_F", 16'(fgl), 16'd0);
        chk("tear_frame_start", {15'h0000, obs_fs}, 16'h0001);
        measure_frame(lows, fss, fgl);
        chk("tear_F_next_frame", 16'(fgl), 16'd24);

        // Blink and enable
        digits       = 16'h4321;
        digit_enable = 4'b1101;
        blink_mask   = 4'b0001;
        run(9 * FRAME);

        // Decode coverage with decimal points
        digit_enable   = 4'hF;
        blink_mask     = 4'h0;
        digits         = 16'h89AB;
        decimal_points = 4'b1010;
        run(2 * FRAME);
        digits         = 16'hCDEF;
        decimal_points = 4'b0101;
        run(FRAME);
        digits         = 16'h0567;
        decimal_points = 4'($urandom);
        brightness     = 2'd2;
        run(2 * FRAME);

        // Reset while digit 2 is lit
        brightness = 2'd3;
        k = 0;
        while (!(((n / P) % SLOT) >= 2 && (((n / P) / SLOT) % N) == 2) && k < 2 * FRAME) begin
            step();
            k++;
        end
        chk("mid_slot_reached", {12'h000, obs_an}, 16'h000B);
        rst_n = 1'b0;
        step();
        chk("midrst_seg", {8'h00, segments}, 16'h00FF);
        chk("midrst_an", {12'h000, anodes}, 16'h000F);
        rst_n = 1'b1;
        sync_frame();
        chk("restart_frame_len", 16'(n), 16'(FRAME));
        run(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
